// File: rtl/crossing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : crossing_sequencer
//  Description : Game controller for the cat/dog/mouse river-crossing puzzle.
//                Boards at most one animal into the canoe, animates each
//                crossing on 4 Hz ticks, moves banks, counts trips, and
//                resolves eat/fight conflicts, the win condition and the
//                trip limit into gameState.
//  Ports       : clk_1kHz        system clock
//                btn_0_out       synchronous active-high reset
//                tick_4Hz        one-cycle animation enable
//                btn_7/6/5_out   cat / dog / mouse buttons (debounced level)
//                btn_4_out       canoe "go" button (debounced level)
//                sw5             difficulty select (1 = hard)
//                *_position      0 = left bank, 1 = right bank
//                passenger       one-hot {mouse,dog,cat}, 000 = empty
//                *_crossing      crossing animation flags
//                anim_step       crossing progress, 0 outside a crossing
//                cnt_canoe       completed trips (saturating)
//                gameDifficulty  0 = easy, 1 = hard
//                gameState       0 = fail, 1 = success, 2 = continue
//  Revision    : 1.0  initial release
// ============================================================================
module crossing_sequencer #(
  parameter int CROSS_TICKS = 4,
  parameter int LIMIT_EASY  = 15,
  parameter int LIMIT_HARD  = 7
) (
  input  logic       clk_1kHz,
  input  logic       btn_0_out,
  input  logic       tick_4Hz,
  input  logic       btn_7_out,
  input  logic       btn_6_out,
  input  logic       btn_5_out,
  input  logic       btn_4_out,
  input  logic       sw5,
  output logic       cat_position,
  output logic       dog_position,
  output logic       mouse_position,
  output logic       canoe_position,
  output logic [2:0] passenger,
  output logic       cat_crossing,
  output logic       dog_crossing,
  output logic       mouse_crossing,
  output logic       canoe_crossing,
  output logic [2:0] anim_step,
  output logic [3:0] cnt_canoe,
  output logic [1:0] gameDifficulty,
  output logic [1:0] gameState
);

  typedef enum logic [2:0] {
    S_BOARD = 3'd0,
    S_CROSS = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [2:0] c_LAST_STEP  = 3'(CROSS_TICKS - 1);
  localparam logic [3:0] c_LIMIT_EASY = 4'(LIMIT_EASY);
  localparam logic [3:0] c_LIMIT_HARD = 4'(LIMIT_HARD);
  localparam logic [1:0] c_GS_FAIL    = 2'd0;
  localparam logic [1:0] c_GS_WIN     = 2'd1;
  localparam logic [1:0] c_GS_CONT    = 2'd2;

  state_t     r_state;
  state_t     w_state_next;

  // Button vector bit order: {go, mouse, dog, cat}
  logic [3:0] w_btn;
  logic [3:0] r_prev;
  logic [3:0] w_rise;

  // Animal vectors bit order: {mouse, dog, cat}
  logic [2:0] r_pos;
  logic       r_canoe;
  logic [2:0] r_passenger;
  logic [2:0] r_anim;
  logic [3:0] r_cnt;
  logic [1:0] r_diff;
  logic [1:0] r_gs;

  logic [2:0] w_sel;
  logic       w_sel_pos;
  logic       w_tick_last;
  logic [3:0] w_limit;
  logic       w_conflict;
  logic       w_all_right;
  logic       w_over_limit;

  assign w_btn  = {btn_4_out, btn_5_out, btn_6_out, btn_7_out};
  assign w_rise = w_btn & ~r_prev;

  // Only the highest-priority rising animal acts, even if its own request
  // turns out to be illegal; lower-priority rises that cycle are dropped.
  always_comb begin
    w_sel = 3'b000;
    if (w_rise[0])      w_sel = 3'b001;
    else if (w_rise[1]) w_sel = 3'b010;
    else if (w_rise[2]) w_sel = 3'b100;
  end

  assign w_sel_pos   = |(w_sel & r_pos);
  assign w_tick_last = tick_4Hz && (r_anim == c_LAST_STEP);
  assign w_limit     = r_diff[0] ? c_LIMIT_HARD : c_LIMIT_EASY;

  // The canoe's bank is the attended one; cat left with dog or mouse on the
  // other bank is the losing situation.
  assign w_conflict   = ((r_pos[0] == r_pos[1]) || (r_pos[0] == r_pos[2])) &&
                        (r_canoe != r_pos[0]);
  assign w_all_right  = (&r_pos) && r_canoe;
  assign w_over_limit = (r_cnt >= w_limit);

  always_ff @(posedge clk_1kHz) begin
    if (btn_0_out) r_state <= S_BOARD;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BOARD: if (w_rise[3])   w_state_next = S_CROSS;
      S_CROSS: if (w_tick_last) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_conflict)        w_state_next = S_LOSE;
        else if (w_all_right)  w_state_next = S_WIN;
        else if (w_over_limit) w_state_next = S_LOSE;
        else                   w_state_next = S_BOARD;
      end
      S_WIN:   w_state_next = S_WIN;
      S_LOSE:  w_state_next = S_LOSE;
      default: w_state_next = S_BOARD;
    endcase
  end

  always_ff @(posedge clk_1kHz) begin
    if (btn_0_out) begin
      // History starts high so buttons held through reset do not fire.
      r_prev      <= 4'b1111;
      r_pos       <= 3'b000;
      r_canoe     <= 1'b0;
      r_passenger <= 3'b000;
      r_anim      <= 3'd0;
      r_cnt       <= 4'd0;
      r_diff      <= {1'b0, sw5};
      r_gs        <= c_GS_CONT;
    end else begin
      r_prev <= w_btn;
      case (r_state)
        S_BOARD: begin
          if (r_cnt == 4'd0) r_diff <= {1'b0, sw5};
          if (w_rise[3]) begin
            r_anim <= 3'd0;
          end else if (w_sel != 3'b000) begin
            if ((r_passenger == 3'b000) && (w_sel_pos == r_canoe))
              r_passenger <= w_sel;
            else if ((r_passenger & w_sel) != 3'b000)
              r_passenger <= 3'b000;
          end
        end
        S_CROSS: begin
          if (w_tick_last) begin
            r_canoe     <= ~r_canoe;
            r_pos       <= r_pos ^ r_passenger;
            r_passenger <= 3'b000;
            r_anim      <= 3'd0;
            if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
          end else if (tick_4Hz) begin
            r_anim <= r_anim + 3'd1;
          end
        end
        S_CHECK: begin
          if (w_conflict)        r_gs <= c_GS_FAIL;
          else if (w_all_right)  r_gs <= c_GS_WIN;
          else if (w_over_limit) r_gs <= c_GS_FAIL;
        end
        default: ;
      endcase
    end
  end

  assign cat_position   = r_pos[0];
  assign dog_position   = r_pos[1];
  assign mouse_position = r_pos[2];
  assign canoe_position = r_canoe;
  assign passenger      = r_passenger;
  assign canoe_crossing = (r_state == S_CROSS);
  assign cat_crossing   = canoe_crossing && r_passenger[0];
  assign dog_crossing   = canoe_crossing && r_passenger[1];
  assign mouse_crossing = canoe_crossing && r_passenger[2];
  assign anim_step      = r_anim;
  assign cnt_canoe      = r_cnt;
  assign gameDifficulty = r_diff;
  assign gameState      = r_gs;

endmodule
`default_nettype wire

// File: tb/tb_crossing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crossing_sequencer
//  Description : Directed scoreboard bench for crossing_sequencer. The driver
//                pushes hand-derived expected output snapshots into a queue;
//                a monitor pops and compares them against the DUT outputs on
//                the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crossing_sequencer;

  localparam int CT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       b_cat = 1'b0, b_dog = 1'b0, b_mouse = 1'b0, b_go = 1'b0;
  logic       sw5 = 1'b0;

  logic       cat_position, dog_position, mouse_position, canoe_position;
  logic [2:0] passenger;
  logic       cat_crossing, dog_crossing, mouse_crossing, canoe_crossing;
  logic [2:0] anim_step;
  logic [3:0] cnt_canoe;
  logic [1:0] gameDifficulty;
  logic [1:0] gameState;

  crossing_sequencer #(.CROSS_TICKS(CT), .LIMIT_EASY(15), .LIMIT_HARD(7)) dut (
    .clk_1kHz       (clk),
    .btn_0_out      (rst),
    .tick_4Hz       (tick),
    .btn_7_out      (b_cat),
    .btn_6_out      (b_dog),
    .btn_5_out      (b_mouse),
    .btn_4_out      (b_go),
    .sw5            (sw5),
    .cat_position   (cat_position),
    .dog_position   (dog_position),
    .mouse_position (mouse_position),
    .canoe_position (canoe_position),
    .passenger      (passenger),
    .cat_crossing   (cat_crossing),
    .dog_crossing   (dog_crossing),
    .mouse_crossing (mouse_crossing),
    .canoe_crossing (canoe_crossing),
    .anim_step      (anim_step),
    .cnt_canoe      (cnt_canoe),
    .gameDifficulty (gameDifficulty),
    .gameState      (gameState)
  );

  always #5 clk = ~clk;

  // Snapshot: {cat,dog,mouse,canoe pos, passenger, cat/dog/mouse/canoe xing,
  //            anim, cnt, diff, state}
  logic [21:0] w_act;
  assign w_act = {cat_position, dog_position, mouse_position, canoe_position,
                  passenger, cat_crossing, dog_crossing, mouse_crossing,
                  canoe_crossing, anim_step, cnt_canoe, gameDifficulty, gameState};

  // Hand-tracked expected state, {mouse,dog,cat} bit order like passenger.
  logic [2:0] e_pos, e_pass, e_anim;
  logic       e_canoe, e_xing;
  logic [3:0] e_cnt;
  logic [1:0] e_diff, e_gs;

  logic [21:0] q_exp[$];
  string       q_name[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [21:0] exp_vec();
    logic [3:0] x;
    x = e_xing ? {e_pass[0], e_pass[1], e_pass[2], 1'b1} : 4'b0000;
    return {e_pos[0], e_pos[1], e_pos[2], e_canoe, e_pass, x,
            e_anim, e_cnt, e_diff, e_gs};
  endfunction

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    logic [21:0] ev;
    string       nm;
    forever begin
      @(negedge clk);
      while (q_exp.size() > 0) begin
        ev = q_exp.pop_front();
        nm = q_name.pop_front();
        checks++;
        if (w_act !== ev) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, w_act, ev);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_now(input string nm);
    q_exp.push_back(exp_vec());
    q_name.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // mask bit order: {go, mouse, dog, cat}
  task automatic press(input logic [3:0] m);
    @(posedge clk); #1;
    {b_go, b_mouse, b_dog, b_cat} = m;
    @(posedge clk); #1;
    {b_go, b_mouse, b_dog, b_cat} = 4'b0000;
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic model_reset();
    e_pos = 3'b000; e_pass = 3'b000; e_anim = 3'd0; e_canoe = 1'b0;
    e_xing = 1'b0; e_cnt = 4'd0; e_diff = {1'b0, sw5}; e_gs = 2'd2;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One complete trip: optional boarding, go, CT ticks, then the CHECK cycle.
  task automatic trip(input logic [2:0] animal, input logic [1:0] gs_after,
                      input string nm);
    if (animal != 3'b000) begin
      press({1'b0, animal});
      e_pass = animal;
      expect_now({nm, " board"});
    end
    press(4'b1000);
    e_xing = 1'b1; e_anim = 3'd0;
    expect_now({nm, " go"});
    repeat (CT - 1) pulse_tick();
    e_anim = 3'(CT - 1);
    expect_now({nm, " anim"});
    pulse_tick();
    e_pos = e_pos ^ e_pass; e_canoe = ~e_canoe; e_pass = 3'b000;
    e_xing = 1'b0; e_anim = 3'd0;
    if (e_cnt != 4'hF) e_cnt = e_cnt + 4'd1;
    expect_now({nm, " arrive"});
    @(posedge clk); #1;
    e_gs = gs_after;
    expect_now({nm, " state"});
  endtask

  initial begin
    // Reset with cat held through it: release must not board the cat.
    b_cat = 1'b1;
    do_reset(3);
    expect_now("reset");
    @(posedge clk); #1;
    b_cat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_now("held_through_reset");

    // Easy solution in 7 trips.
    trip(3'b001, 2'd2, "t1_cat");
    trip(3'b000, 2'd2, "t2_empty");
    trip(3'b010, 2'd2, "t3_dog");
    trip(3'b001, 2'd2, "t4_cat_back");
    trip(3'b100, 2'd2, "t5_mouse");
    trip(3'b000, 2'd2, "t6_empty");
    trip(3'b001, 2'd1, "t7_win");
    press(4'b1111);
    pulse_tick();
    expect_now("win_hold");

    // Dog first leaves cat and mouse unattended.
    do_reset(2);
    trip(3'b010, 2'd0, "dog_first");
    press(4'b0001);
    press(4'b1000);
    pulse_tick();
    expect_now("lose_hold");

    // Hard: difficulty follows sw5 before the first trip, frozen afterwards.
    sw5 = 1'b0;
    do_reset(2);
    sw5 = 1'b1;
    @(posedge clk); #1;
    e_diff = 2'd1;
    expect_now("diff_relatch");
    for (int i = 1; i <= 7; i++) begin
      trip(3'b001, (i == 7) ? 2'd0 : 2'd2, $sformatf("hard_t%0d", i));
      if (i == 1) sw5 = 1'b0;
    end

    // Easy: same shuttle stays in play after 7 trips.
    sw5 = 1'b0;
    do_reset(2);
    for (int i = 1; i <= 7; i++)
      trip(3'b001, 2'd2, $sformatf("easy_t%0d", i));

    // Boarding rules.
    do_reset(2);
    press(4'b0011);
    e_pass = 3'b001;
    expect_now("cat_dog_same_cycle");
    press(4'b0100);
    expect_now("mouse_while_full");
    press(4'b0001);
    e_pass = 3'b000;
    expect_now("unload_cat");
    trip(3'b001, 2'd2, "far_t1");
    trip(3'b000, 2'd2, "far_t2");
    press(4'b0001);
    expect_now("far_bank_ignored");

    // Mid-crossing buttons ignored, then reset wins.
    press(4'b0100);
    e_pass = 3'b100;
    expect_now("mid_board");
    press(4'b1000);
    e_xing = 1'b1; e_anim = 3'd0;
    expect_now("mid_go");
    repeat (2) pulse_tick();
    e_anim = 3'd2;
    press(4'b1111);
    expect_now("mid_buttons");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    expect_now("mid_reset");

    repeat (2) @(posedge clk);
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
